// File: rtl/axil_dmem.sv
// AXI4-Lite single-port data memory with independent AW/W holding registers, a four-state read FSM
// and an alternating-priority arbiter between write commit and read sample.
//   state   | meaning
//   R_IDLE  | ARREADY high, waiting for an AR beat
//   R_ACC   | address held, waiting for the memory port grant
//   R_PIPE  | sampled data ageing through the extra read-latency cycles
//   R_VALID | RVALID high, RDATA/RRESP held until RREADY
module axil_dmem #(
   parameter int MEM_WORDS  = 1024,
   parameter int AXI_AWIDTH = 14,
   parameter int AXI_DWIDTH = 32,
   parameter int RD_LATENCY = 1
) (
   input  logic                      AXI_ACLK,
   input  logic                      AXI_ARESETN,
   input  logic [AXI_AWIDTH-1:0]     AXI_AWADDR,
   input  logic                      AXI_AWVALID,
   output logic                      AXI_AWREADY,
   input  logic [AXI_DWIDTH-1:0]     AXI_WDATA,
   input  logic [AXI_DWIDTH/8-1:0]   AXI_WSTRB,
   input  logic                      AXI_WVALID,
   output logic                      AXI_WREADY,
   output logic [1:0]                AXI_BRESP,
   output logic                      AXI_BVALID,
   input  logic                      AXI_BREADY,
   input  logic [AXI_AWIDTH-1:0]     AXI_ARADDR,
   input  logic                      AXI_ARVALID,
   output logic                      AXI_ARREADY,
   output logic [AXI_DWIDTH-1:0]     AXI_RDATA,
   output logic [1:0]                AXI_RRESP,
   output logic                      AXI_RVALID,
   input  logic                      AXI_RREADY
);
   localparam int STRB_W = AXI_DWIDTH/8;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam int MEM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [1:0] R_IDLE  = 2'd0;
   localparam logic [1:0] R_ACC   = 2'd1;
   localparam logic [1:0] R_PIPE  = 2'd2;
   localparam logic [1:0] R_VALID = 2'd3;

   localparam logic [1:0] PIPE_INIT = (RD_LATENCY > 1) ? 2'(RD_LATENCY - 2) : 2'd0;

   logic [AXI_DWIDTH-1:0] mem_q [MEM_WORDS];

   logic                  aw_full_q, aw_full_d, w_full_q, w_full_d;
   logic                  awready_q, wready_q;
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic [AXI_AWIDTH-1:0] aw_addr_q;
   logic [AXI_DWIDTH-1:0] w_data_q;
   logic [STRB_W-1:0]     w_strb_q;
   logic                  wr_prio_q;

   logic [1:0]            r_state_q, r_state_d;
   logic [1:0]            pipe_cnt_q, pipe_cnt_d;
   logic                  arready_q;
   logic [AXI_AWIDTH-1:0] ar_addr_q;
   logic [AXI_DWIDTH-1:0] rdata_q;
   logic [1:0]            rresp_q;

   logic                  aw_hs, w_hs, ar_hs;
   logic                  wr_req, rd_req, wr_grant, rd_grant;
   logic [AXI_AWIDTH-1:0] aw_word, ar_word;
   logic                  aw_ok, ar_ok;

   assign aw_hs = AXI_AWVALID && awready_q;
   assign w_hs  = AXI_WVALID && wready_q;
   assign ar_hs = AXI_ARVALID && arready_q;

   assign aw_word = aw_addr_q >> OFF_W;
   assign ar_word = ar_addr_q >> OFF_W;
   assign aw_ok   = {{(64-AXI_AWIDTH){1'b0}}, aw_word} < 64'(MEM_WORDS);
   assign ar_ok   = {{(64-AXI_AWIDTH){1'b0}}, ar_word} < 64'(MEM_WORDS);

   // On a conflict the side that lost last time wins; wr_prio_q says who that is.
   assign wr_req   = aw_full_q && w_full_q && !bvalid_q;
   assign rd_req   = (r_state_q == R_ACC);
   assign wr_grant = wr_req && (!rd_req || wr_prio_q);
   assign rd_grant = rd_req && (!wr_req || !wr_prio_q);

   always_comb begin
      aw_full_d = aw_full_q;
      w_full_d  = w_full_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      if (wr_grant) begin
         aw_full_d = 1'b0;
         w_full_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = aw_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_q && AXI_BREADY) begin
         bvalid_d = 1'b0;
      end
      if (aw_hs) aw_full_d = 1'b1;
      if (w_hs)  w_full_d  = 1'b1;
   end

   always_ff @(posedge AXI_ACLK) begin
      if (!AXI_ARESETN) begin
         aw_full_q <= 1'b0;
         w_full_q  <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         wr_prio_q <= 1'b1;
      end else begin
         aw_full_q <= aw_full_d;
         w_full_q  <= w_full_d;
         awready_q <= !aw_full_d;
         wready_q  <= !w_full_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         if (wr_req && rd_req) wr_prio_q <= !wr_grant;
      end
   end

   always_ff @(posedge AXI_ACLK) begin
      if (aw_hs) aw_addr_q <= AXI_AWADDR;
      if (w_hs) begin
         w_data_q <= AXI_WDATA;
         w_strb_q <= AXI_WSTRB;
      end
   end

   always_ff @(posedge AXI_ACLK) begin
      if (AXI_ARESETN && wr_grant && aw_ok) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (w_strb_q[i]) mem_q[aw_word[MEM_AW-1:0]][8*i +: 8] <= w_data_q[8*i +: 8];
         end
      end
   end

   always_comb begin
      r_state_d  = r_state_q;
      pipe_cnt_d = pipe_cnt_q;
      case (r_state_q)
         R_IDLE: if (ar_hs) r_state_d = R_ACC;
         R_ACC: begin
            if (rd_grant) begin
               if (RD_LATENCY > 1) begin
                  r_state_d  = R_PIPE;
                  pipe_cnt_d = PIPE_INIT;
               end else begin
                  r_state_d = R_VALID;
               end
            end
         end
         R_PIPE: begin
            if (pipe_cnt_q == 2'd0) r_state_d = R_VALID;
            else                    pipe_cnt_d = pipe_cnt_q - 2'd1;
         end
         R_VALID: if (AXI_RREADY) r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge AXI_ACLK) begin
      if (!AXI_ARESETN) begin
         r_state_q  <= R_IDLE;
         pipe_cnt_q <= 2'd0;
         arready_q  <= 1'b0;
         ar_addr_q  <= '0;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
      end else begin
         r_state_q  <= r_state_d;
         pipe_cnt_q <= pipe_cnt_d;
         arready_q  <= (r_state_d == R_IDLE);
         if (ar_hs) ar_addr_q <= AXI_ARADDR;
         if (rd_grant) begin
            rdata_q <= ar_ok ? mem_q[ar_word[MEM_AW-1:0]] : '0;
            rresp_q <= ar_ok ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   assign AXI_AWREADY = awready_q;
   assign AXI_WREADY  = wready_q;
   assign AXI_BVALID  = bvalid_q;
   assign AXI_BRESP   = bresp_q;
   assign AXI_ARREADY = arready_q;
   assign AXI_RVALID  = (r_state_q == R_VALID);
   assign AXI_RDATA   = rdata_q;
   assign AXI_RRESP   = rresp_q;
endmodule
